// File: rtl/ravenoc_pkg.sv
// Shared types and constants for the RaveNoC router datapath.
package ravenoc_pkg;

  // Flit framing carried alongside each payload
  typedef enum logic [1:0] {
    HEAD_FLIT      = 2'b00,
    BODY_FLIT      = 2'b01,
    TAIL_FLIT      = 2'b10,
    HEAD_TAIL_FLIT = 2'b11
  } flit_type_t;

  // Port indices of the default 5-port mesh router
  localparam int unsigned NORTH_PORT = 0;
  localparam int unsigned SOUTH_PORT = 1;
  localparam int unsigned WEST_PORT  = 2;
  localparam int unsigned EAST_PORT  = 3;
  localparam int unsigned LOCAL_PORT = 4;

  localparam int unsigned DEFAULT_NUM_PORTS = LOCAL_PORT + 1;

  // Per-output switch allocation state
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } s_alloc_state_t;

endpackage

// File: rtl/rr_arbiter_n.sv
// N-request one-hot round-robin arbiter. The pointer names the last winner;
// the search starts one position after it and wraps.
module rr_arbiter_n #(
  parameter int unsigned N  = 5,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  logic          found;
  logic [IW-1:0] idx;

  // First requester at or after ptr_i+1 (mod N) wins
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= int'(N); k++) begin
      idx = IW'((int'(ptr_i) + k) % int'(N));
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_switch_alloc.sv
// N x N switch allocator and crossbar: per-output round-robin arbitration of
// head flits, wormhole locking until the tail, one registered stage per output.
module router_switch_alloc
  import ravenoc_pkg::*;
#(
  parameter int unsigned NUM_PORTS   = DEFAULT_NUM_PORTS,
  parameter int unsigned FLIT_WIDTH  = 32,
  parameter bit          ALLOW_UTURN = 1'b0
) (
  input  logic                            clk,
  input  logic                            arst,
  input  logic [NUM_PORTS-1:0]            in_valid_i,
  output logic [NUM_PORTS-1:0]            in_ready_o,
  input  logic [NUM_PORTS*FLIT_WIDTH-1:0] in_flit_i,
  input  logic [NUM_PORTS*2-1:0]          in_type_i,
  input  logic [NUM_PORTS*NUM_PORTS-1:0]  in_route_i,
  output logic [NUM_PORTS-1:0]            out_valid_o,
  input  logic [NUM_PORTS-1:0]            out_ready_i,
  output logic [NUM_PORTS*FLIT_WIDTH-1:0] out_flit_o,
  output logic [NUM_PORTS*2-1:0]          out_type_o,
  output logic [NUM_PORTS*NUM_PORTS-1:0]  out_src_o,
  output logic [NUM_PORTS-1:0]            lock_o,
  output logic [NUM_PORTS-1:0]            route_err_o
);

  localparam int unsigned IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  // Unpacked per-input views
  logic [FLIT_WIDTH-1:0] flit  [NUM_PORTS];
  flit_type_t            ftype [NUM_PORTS];
  logic [NUM_PORTS-1:0]  route [NUM_PORTS];

  logic [NUM_PORTS-1:0] is_head;
  logic [NUM_PORTS-1:0] legal;
  logic [NUM_PORTS-1:0] owns_any;
  logic [NUM_PORTS-1:0] head_ok;
  logic [NUM_PORTS-1:0] err_set;
  logic [NUM_PORTS-1:0] err_q;

  // Per-output exports: ready contribution to each input, lock and owner
  logic [NUM_PORTS-1:0] rdy_mat   [NUM_PORTS];
  logic [NUM_PORTS-1:0] lock_vec;
  logic [IW-1:0]        owner_vec [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
    assign flit[i]    = in_flit_i[i*FLIT_WIDTH +: FLIT_WIDTH];
    assign ftype[i]   = flit_type_t'(in_type_i[i*2 +: 2]);
    assign route[i]   = in_route_i[i*NUM_PORTS +: NUM_PORTS];
    assign is_head[i] = (ftype[i] == HEAD_FLIT) || (ftype[i] == HEAD_TAIL_FLIT);
    // Exactly one-hot, and no U-turn unless allowed
    assign legal[i]   = (route[i] != '0) && ((route[i] & (route[i] - 1'b1)) == '0) &&
                        (ALLOW_UTURN || !route[i][i]);
  end

  // An input owning any output is mid-packet; a new head from it is a protocol error
  always_comb begin
    owns_any = '0;
    for (int o = 0; o < int'(NUM_PORTS); o++) begin
      if (lock_vec[o]) owns_any[owner_vec[o]] = 1'b1;
    end
  end

  assign head_ok = in_valid_i & is_head & legal & ~owns_any;
  assign err_set = in_valid_i & is_head & (~legal | owns_any);

  // Sticky per-input route/protocol error flags
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      err_q <= '0;
    end else begin
      err_q <= err_q | err_set;
    end
  end

  assign route_err_o = err_q;

  // Merge per-output ready contributions; nothing is accepted during reset
  always_comb begin
    in_ready_o = '0;
    if (arst) begin
      for (int o = 0; o < int'(NUM_PORTS); o++) begin
        in_ready_o = in_ready_o | rdy_mat[o];
      end
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    logic [NUM_PORTS-1:0]  req;
    logic [NUM_PORTS-1:0]  gnt;
    logic [NUM_PORTS-1:0]  rdy;
    s_alloc_state_t        state_q, state_d;
    logic [IW-1:0]         owner_q, owner_d;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic [IW-1:0]         sel;
    logic                  slot_free;
    logic                  load;
    logic                  valid_q;
    logic [FLIT_WIDTH-1:0] flit_q;
    logic [1:0]            type_q;
    logic [NUM_PORTS-1:0]  src_q;

    // Head candidates routed to this output
    always_comb begin
      req = '0;
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
        req[i] = head_ok[i] & route[i][o];
      end
    end

    rr_arbiter_n #(
      .N  (NUM_PORTS),
      .IW (IW)
    ) u_arb (
      .req_i (req),
      .ptr_i (ptr_q),
      .gnt_o (gnt)
    );

    assign slot_free = !valid_q | out_ready_i[o];

    // FSM outputs: selected input and its ready, gated by slot availability
    always_comb begin
      sel = owner_q;
      rdy = '0;
      if (state_q == IDLE) begin
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
          if (gnt[i]) sel = IW'(i);
        end
        rdy = gnt & {NUM_PORTS{slot_free}};
      end else if ((ftype[owner_q] == BODY_FLIT) || (ftype[owner_q] == TAIL_FLIT)) begin
        rdy[owner_q] = slot_free;
      end
    end

    assign load = arst & in_valid_i[sel] & rdy[sel];

    // FSM next state: heads lock and move the pointer, tails release
    always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      unique case (state_q)
        IDLE: begin
          if (load) begin
            ptr_d = sel;
            if (ftype[sel] == HEAD_FLIT) begin
              state_d = LOCKED;
              owner_d = sel;
            end
          end
        end
        LOCKED: begin
          if (load && (ftype[sel] == TAIL_FLIT)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // FSM state register; pointer starts at the last port so input 0 goes first
    always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
        state_q <= IDLE;
        owner_q <= '0;
        ptr_q   <= IW'(NUM_PORTS - 1);
      end else begin
        state_q <= state_d;
        owner_q <= owner_d;
        ptr_q   <= ptr_d;
      end
    end

    // Output register: load and drain may coincide; contents hold while stalled
    always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
        valid_q <= 1'b0;
        flit_q  <= '0;
        type_q  <= '0;
        src_q   <= '0;
      end else if (load) begin
        valid_q <= 1'b1;
        flit_q  <= flit[sel];
        type_q  <= ftype[sel];
        src_q   <= NUM_PORTS'(1) << sel;
      end else if (out_ready_i[o]) begin
        valid_q <= 1'b0;
      end
    end

    assign lock_vec[o]  = (state_q == LOCKED);
    assign owner_vec[o] = owner_q;
    assign rdy_mat[o]   = rdy;

    assign out_valid_o[o]                          = valid_q;
    assign out_flit_o[o*FLIT_WIDTH +: FLIT_WIDTH]  = flit_q;
    assign out_type_o[o*2 +: 2]                    = type_q;
    assign out_src_o[o*NUM_PORTS +: NUM_PORTS]     = src_q;
    assign lock_o[o]                               = lock_vec[o];
  end

endmodule

// File: tb/tb_router_switch_alloc.sv
// Directed bench for router_switch_alloc (5 ports, 32-bit flits, no U-turn).
module tb_router_switch_alloc;

  localparam int N  = 5;
  localparam int FW = 32;

  localparam logic [1:0] TH  = 2'b00;
  localparam logic [1:0] TB  = 2'b01;
  localparam logic [1:0] TT  = 2'b10;
  localparam logic [1:0] THT = 2'b11;

  logic            clk = 1'b0;
  logic            arst = 1'b0;
  logic [N-1:0]    in_valid = '0, in_ready, out_valid, out_ready = '1, lock, route_err;
  logic [N*FW-1:0] in_flit = '0, out_flit;
  logic [N*2-1:0]  in_type = '0, out_type;
  logic [N*N-1:0]  in_route = '0, out_src;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  router_switch_alloc #(
    .NUM_PORTS   (N),
    .FLIT_WIDTH  (FW),
    .ALLOW_UTURN (1'b0)
  ) dut (
    .clk         (clk),
    .arst        (arst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_flit_i   (in_flit),
    .in_type_i   (in_type),
    .in_route_i  (in_route),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_flit_o  (out_flit),
    .out_type_o  (out_type),
    .out_src_o   (out_src),
    .lock_o      (lock),
    .route_err_o (route_err)
  );

  task automatic drive(input int i, input logic v, input logic [1:0] t,
                       input logic [N-1:0] r, input logic [FW-1:0] f);
    in_valid[i]        = v;
    in_type[i*2 +: 2]  = t;
    in_route[i*N +: N] = r;
    in_flit[i*FW +: FW] = f;
  endtask

  task automatic clear_inputs();
    in_valid = '0;
    in_type  = '0;
    in_route = '0;
    in_flit  = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arst = 1'b0;
    clear_inputs();
    drive(0, 1'b1, THT, 5'b00010, 32'h1111_0000);
    #2;
    compared++;
    if (in_ready !== 5'b0) begin
      mismatched++; $display("FAIL reset_in_ready: got %b want 00000", in_ready);
    end
    compared++;
    if (out_valid !== 5'b0) begin
      mismatched++; $display("FAIL reset_out_valid: got %b want 00000", out_valid);
    end
    compared++;
    if (lock !== 5'b0 || route_err !== 5'b0) begin
      mismatched++; $display("FAIL reset_lock_err: got %b/%b want 0/0", lock, route_err);
    end
    compared++;
    if (out_src !== '0 || out_flit !== '0 || out_type !== '0) begin
      mismatched++; $display("FAIL reset_out_regs: got src %h flit %h type %h want 0", out_src,
                             out_flit, out_type);
    end
    step();
    clear_inputs();
    step();
    arst = 1'b1;
    step();
  endtask

  task automatic test_head_tail();
    clear_inputs();
    out_ready = '1;
    drive(4, 1'b1, THT, 5'b00001, 32'hCAFE_0004);
    #1;
    compared++;
    if (in_ready !== 5'b10000) begin
      mismatched++; $display("FAIL ht_in_ready: got %b want 10000", in_ready);
    end
    step();
    clear_inputs();
    compared++;
    if (out_valid !== 5'b00001 || out_flit[0 +: FW] !== 32'hCAFE_0004 || out_type[1:0] !== THT)
    begin
      mismatched++; $display("FAIL ht_out: got v %b flit %h type %b want 00001 cafe0004 11",
                             out_valid, out_flit[0 +: FW], out_type[1:0]);
    end
    compared++;
    if (out_src[0 +: N] !== 5'b10000 || lock !== 5'b0) begin
      mismatched++; $display("FAIL ht_src_lock: got src %b lock %b want 10000 00000",
                             out_src[0 +: N], lock);
    end
    step();
    compared++;
    if (out_valid !== 5'b0) begin
      mismatched++; $display("FAIL ht_drain: got %b want 00000", out_valid);
    end
  endtask

  task automatic test_wormhole();
    logic [N-1:0]  exp_rdy  [7];
    logic [FW-1:0] exp_flit [7];
    logic [N-1:0]  exp_src  [7];
    logic          exp_vld  [7];
    logic          exp_lck  [7];
    logic [1:0]    pt       [3];
    int p1, p3;
    exp_rdy  = '{5'b00010, 5'b00010, 5'b00010, 5'b01000, 5'b01000, 5'b01000, 5'b00000};
    exp_flit = '{32'h1000_0000, 32'h1000_0001, 32'h1000_0002,
                 32'h3000_0000, 32'h3000_0001, 32'h3000_0002, 32'h0};
    exp_src  = '{5'b00010, 5'b00010, 5'b00010, 5'b01000, 5'b01000, 5'b01000, 5'b01000};
    exp_vld  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_lck  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    pt       = '{TH, TB, TT};
    p1 = 0;
    p3 = 0;
    clear_inputs();
    out_ready = '1;
    for (int k = 0; k < 7; k++) begin
      if (p1 < 3) drive(1, 1'b1, pt[p1], 5'b00100, 32'h1000_0000 + p1);
      else        drive(1, 1'b0, TB, 5'b0, 32'h0);
      if (p3 < 3) drive(3, 1'b1, pt[p3], 5'b00100, 32'h3000_0000 + p3);
      else        drive(3, 1'b0, TB, 5'b0, 32'h0);
      #1;
      compared++;
      if (in_ready !== exp_rdy[k]) begin
        mismatched++; $display("FAIL worm_ready[%0d]: got %b want %b", k, in_ready, exp_rdy[k]);
      end
      step();
      if (exp_rdy[k][1]) p1++;
      if (exp_rdy[k][3]) p3++;
      compared++;
      if (out_valid[2] !== exp_vld[k] || lock[2] !== exp_lck[k] ||
          (exp_vld[k] && (out_flit[2*FW +: FW] !== exp_flit[k] ||
                          out_src[2*N +: N] !== exp_src[k]))) begin
        mismatched++;
        $display("FAIL worm_out[%0d]: got v%b l%b flit %h src %b want v%b l%b flit %h src %b",
                 k, out_valid[2], lock[2], out_flit[2*FW +: FW], out_src[2*N +: N],
                 exp_vld[k], exp_lck[k], exp_flit[k], exp_src[k]);
      end
    end
    clear_inputs();
  endtask

  task automatic test_round_robin();
    int seq [9];
    seq = '{0, 1, 2, 3, 0, 1, -1, -1, 2};
    clear_inputs();
    out_ready = '1;
    for (int i = 0; i < 4; i++) drive(i, 1'b1, THT, 5'b10000, 32'hA0 + i);
    for (int k = 0; k < 9; k++) begin
      out_ready[4] = (seq[k] >= 0);
      #1;
      compared++;
      if (in_ready !== ((seq[k] >= 0) ? (5'b1 << seq[k]) : 5'b0)) begin
        mismatched++; $display("FAIL rr_ready[%0d]: got %b want grant %0d", k, in_ready, seq[k]);
      end
      step();
      // During the stall the register still holds input 1's flit
      compared++;
      if (out_valid[4] !== 1'b1 ||
          out_src[4*N +: N] !== ((seq[k] >= 0) ? (5'b1 << seq[k]) : 5'b00010) ||
          out_flit[4*FW +: FW] !== ((seq[k] >= 0) ? (32'hA0 + seq[k]) : 32'hA1)) begin
        mismatched++; $display("FAIL rr_out[%0d]: got v%b src %b flit %h want grant %0d", k,
                               out_valid[4], out_src[4*N +: N], out_flit[4*FW +: FW], seq[k]);
      end
    end
    clear_inputs();
    out_ready = '1;
    step();
  endtask

  task automatic test_stall();
    logic       orr     [10];
    logic       exp_rdy [10];
    int         exp_idx [10];
    logic       exp_lck [10];
    logic [1:0] pt      [4];
    int p;
    orr     = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_idx = '{0, 0, 0, 0, 0, 0, 1, 2, 3, -1};
    exp_lck = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    pt      = '{TH, TB, TB, TT};
    p = 0;
    clear_inputs();
    for (int k = 0; k < 10; k++) begin
      out_ready[1] = orr[k];
      if (p < 4) drive(0, 1'b1, pt[p], 5'b00010, 32'h5000_0000 + p);
      else       drive(0, 1'b0, TB, 5'b0, 32'h0);
      #1;
      compared++;
      if (in_ready !== {4'b0, exp_rdy[k]}) begin
        mismatched++; $display("FAIL stall_ready[%0d]: got %b want %b", k, in_ready, exp_rdy[k]);
      end
      step();
      if (exp_rdy[k]) p++;
      compared++;
      if (out_valid[1] !== (exp_idx[k] >= 0) || lock[1] !== exp_lck[k] ||
          (exp_idx[k] >= 0 && out_flit[1*FW +: FW] !== 32'h5000_0000 + exp_idx[k])) begin
        mismatched++; $display("FAIL stall_out[%0d]: got v%b l%b flit %h want idx %0d l%b", k,
                               out_valid[1], lock[1], out_flit[1*FW +: FW], exp_idx[k],
                               exp_lck[k]);
      end
    end
    clear_inputs();
    out_ready = '1;
  endtask

  task automatic test_protocol_err();
    clear_inputs();
    drive(0, 1'b1, TH, 5'b00010, 32'h7000_0000);
    #1;
    compared++;
    if (in_ready !== 5'b00001) begin
      mismatched++; $display("FAIL proto_head: got %b want 00001", in_ready);
    end
    step();
    drive(0, 1'b1, TH, 5'b00100, 32'h7000_0001);
    #1;
    compared++;
    if (in_ready !== 5'b00000) begin
      mismatched++; $display("FAIL proto_reject: got %b want 00000", in_ready);
    end
    step();
    compared++;
    if (route_err !== 5'b00001 || lock[1] !== 1'b1) begin
      mismatched++; $display("FAIL proto_err: got err %b lock %b want 00001 1", route_err, lock[1]);
    end
    drive(0, 1'b1, TT, 5'b0, 32'h7000_0002);
    #1;
    compared++;
    if (in_ready !== 5'b00001) begin
      mismatched++; $display("FAIL proto_tail: got %b want 00001", in_ready);
    end
    step();
    clear_inputs();
    compared++;
    if (lock !== 5'b0 || out_type[3:2] !== TT || out_flit[1*FW +: FW] !== 32'h7000_0002) begin
      mismatched++; $display("FAIL proto_release: got lock %b type %b flit %h", lock,
                             out_type[3:2], out_flit[1*FW +: FW]);
    end
    step();
  endtask

  task automatic test_route_err();
    clear_inputs();
    arst = 1'b0;
    #2;
    compared++;
    if (route_err !== 5'b0) begin
      mismatched++; $display("FAIL rerr_cleared: got %b want 00000", route_err);
    end
    step();
    arst = 1'b1;
    drive(2, 1'b1, TH, 5'b00101, 32'hBAD0_0002);
    drive(0, 1'b1, THT, 5'b01000, 32'hE0);
    #1;
    compared++;
    if (in_ready !== 5'b00001) begin
      mismatched++; $display("FAIL rerr_ready: got %b want 00001", in_ready);
    end
    step();
    drive(0, 1'b0, TB, 5'b0, 32'h0);
    compared++;
    if (route_err !== 5'b00100 || out_valid !== 5'b01000 || out_src[3*N +: N] !== 5'b00001) begin
      mismatched++; $display("FAIL rerr_multihot: got err %b v %b src %b want 00100 01000 00001",
                             route_err, out_valid, out_src[3*N +: N]);
    end
    #1;
    compared++;
    if (in_ready !== 5'b0) begin
      mismatched++; $display("FAIL rerr_held: got %b want 00000", in_ready);
    end
    step();
    clear_inputs();
    arst = 1'b0;
    #2;
    step();
    arst = 1'b1;
    drive(2, 1'b1, TH, 5'b00100, 32'hBAD0_0003);
    #1;
    compared++;
    if (in_ready !== 5'b0) begin
      mismatched++; $display("FAIL rerr_uturn_ready: got %b want 00000", in_ready);
    end
    step();
    compared++;
    if (route_err !== 5'b00100 || out_valid !== 5'b0) begin
      mismatched++; $display("FAIL rerr_uturn: got err %b v %b want 00100 00000", route_err,
                             out_valid);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_packet();
    clear_inputs();
    out_ready = '1;
    drive(1, 1'b1, TH, 5'b01000, 32'hD1);
    #1;
    compared++;
    if (in_ready !== 5'b00010) begin
      mismatched++; $display("FAIL rmid_head: got %b want 00010", in_ready);
    end
    step();
    out_ready[3] = 1'b0;
    drive(1, 1'b1, TB, 5'b0, 32'hD2);
    #1;
    compared++;
    if (lock[3] !== 1'b1 || out_valid[3] !== 1'b1 || in_ready !== 5'b0) begin
      mismatched++; $display("FAIL rmid_locked: got l%b v%b rdy %b want 1 1 00000", lock[3],
                             out_valid[3], in_ready);
    end
    arst = 1'b0;
    #1;
    compared++;
    if (out_valid !== 5'b0 || lock !== 5'b0 || in_ready !== 5'b0 || out_src !== '0) begin
      mismatched++; $display("FAIL rmid_clear: got v %b l %b rdy %b src %h want 0", out_valid,
                             lock, in_ready, out_src);
    end
    step();
    arst = 1'b1;
    clear_inputs();
    out_ready = '1;
    drive(2, 1'b1, THT, 5'b01000, 32'hD3);
    #1;
    compared++;
    if (in_ready !== 5'b00100) begin
      mismatched++; $display("FAIL rmid_regrant: got %b want 00100", in_ready);
    end
    step();
    clear_inputs();
    compared++;
    if (out_valid !== 5'b01000 || out_src[3*N +: N] !== 5'b00100 ||
        out_flit[3*FW +: FW] !== 32'hD3) begin
      mismatched++; $display("FAIL rmid_out: got v %b src %b flit %h want 01000 00100 d3",
                             out_valid, out_src[3*N +: N], out_flit[3*FW +: FW]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_head_tail();
    test_wormhole();
    test_round_robin();
    test_stall();
    test_protocol_err();
    test_route_err();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
